div_share_ctrl: RTL
===================

Name: div_share_ctrl

Overview:
- Shares one pipelined divider instance (div_pipelined2, WIDTH-bit, latency WIDTH/2+1) among NREQ requesters.
- Round-robin arbitration; at most one new division is issued per cycle.
- Carries requester ID, divide-by-zero flag and dividend alongside the divider pipeline, then routes each result back to its requester.
- Each requester may have one operation outstanding. Sits between the CPU/accelerator divide units and the shared divider.

Parameters:
- WIDTH, 32, operand/result width; must be even, >= 4.
- NREQ, 4, number of requesters, 1..8.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req_valid  in  NREQ  per-requester request
- req_z  in  NREQ*WIDTH  dividends, requester i at bits [i*WIDTH +: WIDTH]
- req_d  in  NREQ*WIDTH  divisors, same packing
- req_ready  out  NREQ  accept; handshake when req_valid[i] & req_ready[i]
- res_valid  out  NREQ  one-hot result strobe, one cycle, no backpressure
- res_quot  out  WIDTH  quotient
- res_rem  out  WIDTH  remainder
- res_dbz  out  1  result was divide-by-zero
- busy  out  NREQ  requester i has an operation in flight

Behaviour:
- Reset (rst==0 at posedge):
  - clears busy, issue register, side pipeline, res_valid, res_quot, res_rem, res_dbz.
  - RR pointer resets to 0.
  - Divider receives the same rst. In-flight operations are discarded; no res_valid for them, ever.
- Eligibility:
  - elig[i] = req_valid[i] & ~busy[i].
  - Grant = first eligible index at or after ptr, searching upward mod NREQ.
  - req_ready is combinational: req_ready[i] = (grant==i) & elig[i]. At most one bit is set.
  - req_ready does not depend on req_valid of other requesters beyond the priority search.
- Accept at posedge k:
  - issue register loads z, d, one-hot id, dbz=(d==0); iss_valid=1.
  - busy[id] set; ptr <= winner+1 mod NREQ.
  - With no accept, iss_valid=0 and the issue z/d are driven to 0.
- Divider samples the issue register at posedge k+1.
- Side pipeline: shift register of depth L=WIDTH/2+1, entries {valid, id, dbz, z}, advanced every cycle.
- Result, registered:
  - res_valid is asserted in the cycle following posedge k+1+L.
  - Total latency from the accept cycle to res_valid = WIDTH/2+2 cycles (18 at WIDTH=32, 10 at WIDTH=16).
  - Back-to-back accepts produce back-to-back results in issue order.
- Divide-by-zero: res_quot = all ones, res_rem = original z, res_dbz=1. The divider output is ignored.
- Normal case: res_quot/res_rem from the divider (unsigned), res_dbz=0.
- res_quot/res_rem/res_dbz hold their last value when res_valid=0.
- busy[i] clears at the same edge that raises res_valid[i].
  - req_ready[i] may therefore be high in the res_valid cycle, so the next op can be accepted that cycle.
  - Set/clear never coincide for the same i, since only one op is outstanding.
- Throughput: 1 op/cycle aggregate. Per requester, 1 op per WIDTH/2+2 cycles.
- NREQ=1: arbitration degenerates, ptr is constant 0.

Test Plan:
- Single op, WIDTH=32, requester 0: z=100, d=7 → res_valid=4'b0001 exactly 18 cycles after accept; quot=14, rem=2, dbz=0; busy[0] high for those 18 cycles.
- Divide by zero: req 2, z=0x1234, d=0 → res_valid[2] after 18 cycles; quot=0xFFFFFFFF, rem=0x1234, dbz=1.
- Contention: all 4 valid from the same cycle with distinct operands → accepts in order 0,1,2,3 on consecutive cycles; results in the same order on consecutive cycles, each correct.
- Fairness and re-issue: req 0 and req 1 held valid continuously. Check:
  - grants alternate by ptr;
  - each requester is re-accepted in its own res_valid cycle;
  - no requester starves over 200 cycles;
  - results match the reference model.
- Reset mid-flight: issue 3 ops, assert rst low for 1 cycle at cycle 5 → no res_valid for the next 40 cycles; busy=0; the next op after reset completes normally with ptr starting at 0.
- Random regression, WIDTH=16: 10k random z/d including d=0, d=1, z<d, z=0xFFFF → every result matches z/d and z%d (or the dbz rule); latency is always 10.

Source files
------------

// File: rtl/div_share_ctrl_if.sv
// Request/result bundle between the divide clients and the shared-divider controller.
// Lane i of req_z/req_d lives at bits [i*WIDTH +: WIDTH].
interface div_share_ctrl_if #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 4
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_z;
   logic [NREQ*WIDTH-1:0] req_d;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       res_valid;
   logic [WIDTH-1:0]      res_quot;
   logic [WIDTH-1:0]      res_rem;
   logic                  res_dbz;
   logic [NREQ-1:0]       busy;

   modport master (
      output req_valid, req_z, req_d,
      input  req_ready, res_valid, res_quot, res_rem, res_dbz, busy
   );

   modport slave (
      input  req_valid, req_z, req_d,
      output req_ready, res_valid, res_quot, res_rem, res_dbz, busy
   );
endinterface

// File: rtl/div_share_ctrl.sv
// Round-robin front end sharing one pipelined unsigned divider among NREQ clients,
// with a side pipeline carrying id/dbz/dividend so results route back to their owner.

// Radix-4 restoring divider: one input register plus WIDTH/2 stages of two steps each.
module div_pipelined2 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] z,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem
);
   localparam int NSTAGE = WIDTH / 2;

   // Index 0 is the input register; index s holds the state after 2*s steps.
   logic [NSTAGE:0][WIDTH-1:0]   r_reg;
   logic [NSTAGE:0][WIDTH-1:0]   q_reg;
   logic [NSTAGE:0][WIDTH-1:0]   d_reg;
   logic [NSTAGE-1:0][WIDTH-1:0] r_next;
   logic [NSTAGE-1:0][WIDTH-1:0] q_next;

   // q carries the unconsumed dividend bits at the top and the quotient bits at the bottom.
   function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                   input logic [WIDTH-1:0] q,
                                                   input logic [WIDTH-1:0] dv);
      logic [WIDTH:0] t;
      logic           ge;
      t  = {r, q[WIDTH-1]};
      ge = (t >= {1'b0, dv});
      if (ge) t = t - {1'b0, dv};
      return {t[WIDTH-1:0], q[WIDTH-2:0], ge};
   endfunction

   generate
      for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
         logic [2*WIDTH-1:0] s1;
         logic [2*WIDTH-1:0] s2;
         assign s1 = div_step(r_reg[gi], q_reg[gi], d_reg[gi]);
         assign s2 = div_step(s1[2*WIDTH-1:WIDTH], s1[WIDTH-1:0], d_reg[gi]);
         assign r_next[gi] = s2[2*WIDTH-1:WIDTH];
         assign q_next[gi] = s2[WIDTH-1:0];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_reg <= '0;
         q_reg <= '0;
         d_reg <= '0;
      end else begin
         r_reg <= {r_next, {WIDTH{1'b0}}};
         q_reg <= {q_next, z};
         d_reg <= {d_reg[NSTAGE-1:0], d};
      end
   end

   assign quot = q_reg[NSTAGE];
   assign rem  = r_reg[NSTAGE];
endmodule

module div_share_ctrl #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 4
) (
   input logic             clk,
   input logic             rst,
   div_share_ctrl_if.slave bus
);
   localparam int LAT = WIDTH / 2 + 1;
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]  busy_reg;
   logic [NREQ-1:0]  busy_next;
   logic [NREQ-1:0]  elig;
   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   ptr_reg;
   logic [IDW-1:0]   ptr_next;
   logic [IDW-1:0]   win;
   logic             found;
   logic [WIDTH-1:0] win_z;
   logic [WIDTH-1:0] win_d;

   logic             iss_valid_reg;
   logic [WIDTH-1:0] iss_z_reg;
   logic [WIDTH-1:0] iss_d_reg;
   logic [NREQ-1:0]  iss_id_reg;
   logic             iss_dbz_reg;

   logic [LAT-1:0]             sp_valid_reg;
   logic [LAT-1:0]             sp_dbz_reg;
   logic [LAT-1:0][NREQ-1:0]   sp_id_reg;
   logic [LAT-1:0][WIDTH-1:0]  sp_z_reg;

   logic             done;
   logic [NREQ-1:0]  done_id;
   logic [WIDTH-1:0] div_quot;
   logic [WIDTH-1:0] div_rem;

   logic [NREQ-1:0]  res_valid_reg;
   logic [WIDTH-1:0] res_quot_reg;
   logic [WIDTH-1:0] res_rem_reg;
   logic             res_dbz_reg;

   assign elig = bus.req_valid & ~busy_reg;

   // First eligible lane at or after ptr, wrapping mod NREQ.
   always_comb begin
      int idx;
      idx   = 0;
      grant = '0;
      win   = '0;
      found = 1'b0;
      for (int o = 0; o < NREQ; o++) begin
         idx = (int'(ptr_reg) + o) % NREQ;
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = IDW'(idx);
         end
      end
      if (found) grant[win] = 1'b1;
   end

   always_comb begin
      ptr_next = ptr_reg;
      if (found) ptr_next = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
   end

   assign win_z = bus.req_z[win*WIDTH +: WIDTH];
   assign win_d = bus.req_d[win*WIDTH +: WIDTH];

   assign done    = sp_valid_reg[LAT-1];
   assign done_id = done ? sp_id_reg[LAT-1] : '0;

   // Only one op per lane is outstanding, so set and clear never hit the same bit.
   assign busy_next = (busy_reg | grant) & ~done_id;

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_reg      <= '0;
         ptr_reg       <= '0;
         iss_valid_reg <= 1'b0;
         iss_z_reg     <= '0;
         iss_d_reg     <= '0;
         iss_id_reg    <= '0;
         iss_dbz_reg   <= 1'b0;
      end else begin
         busy_reg      <= busy_next;
         ptr_reg       <= ptr_next;
         iss_valid_reg <= found;
         iss_z_reg     <= found ? win_z : '0;
         iss_d_reg     <= found ? win_d : '0;
         iss_id_reg    <= grant;
         iss_dbz_reg   <= found && (win_d == '0);
      end
   end

   div_pipelined2 #(.WIDTH(WIDTH)) u_div (
      .clk  (clk),
      .rst  (rst),
      .z    (iss_z_reg),
      .d    (iss_d_reg),
      .quot (div_quot),
      .rem  (div_rem)
   );

   // Side pipeline has exactly the divider's depth so its tail lines up with the divider output.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sp_valid_reg <= '0;
         sp_dbz_reg   <= '0;
         sp_id_reg    <= '0;
         sp_z_reg     <= '0;
      end else begin
         sp_valid_reg <= {sp_valid_reg[LAT-2:0], iss_valid_reg};
         sp_dbz_reg   <= {sp_dbz_reg[LAT-2:0], iss_dbz_reg};
         sp_id_reg    <= {sp_id_reg[LAT-2:0], iss_id_reg};
         sp_z_reg     <= {sp_z_reg[LAT-2:0], iss_z_reg};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         res_valid_reg <= '0;
         res_quot_reg  <= '0;
         res_rem_reg   <= '0;
         res_dbz_reg   <= 1'b0;
      end else begin
         res_valid_reg <= done_id;
         if (done) begin
            res_dbz_reg  <= sp_dbz_reg[LAT-1];
            res_quot_reg <= sp_dbz_reg[LAT-1] ? '1 : div_quot;
            res_rem_reg  <= sp_dbz_reg[LAT-1] ? sp_z_reg[LAT-1] : div_rem;
         end
      end
   end

   assign bus.req_ready = grant;
   assign bus.busy      = busy_reg;
   assign bus.res_valid = res_valid_reg;
   assign bus.res_quot  = res_quot_reg;
   assign bus.res_rem   = res_rem_reg;
   assign bus.res_dbz   = res_dbz_reg;
endmodule
